// File: rtl/signed_digit_decomposer_pkg.sv
// Shared constants and state encoding for the signed digit decomposer.
// Lane count and lane width mirror the NTT lane bus that consumes the digits.
package signed_digit_decomposer_pkg;

    localparam int NTT_NUMBER    = 4;
    localparam int DATA_SIZE_ARB = 16;

    typedef enum logic [1:0] {
        SDD_IDLE = 2'd0,
        SDD_RUN  = 2'd1,
        SDD_DONE = 2'd2
    } sdd_state_e;

endpackage

// File: rtl/signed_digit_decomposer_digit_step.sv
// One balanced base-2^LOG_B digit extraction: x -> (digit mod Q, next x).
// Purely combinational; the caller owns the accumulator register.
module sdd_digit_step #(
    parameter int Q     = 12289,
    parameter int LOG_B = 7,
    parameter int W     = 16
) (
    input  logic signed [W+1:0] x_i,
    output logic        [W-1:0] lane_o,
    output logic signed [W+1:0] next_x_o
);

    localparam int B = 1 << LOG_B;
    localparam logic [LOG_B-1:0] HALF = LOG_B'(B / 2);

    logic        [LOG_B-1:0] r;
    logic signed [W+1:0]     shifted;

    // Digits above B/2 become negative (r - B) and carry one into the next
    // position; a negative digit is stored as Q - (B - r) so lanes stay in [0, Q).
    always_comb begin
        r       = x_i[LOG_B-1:0];
        shifted = x_i >>> LOG_B;
        if (r > HALF) begin
            lane_o   = W'(Q) - W'(B) + W'(r);
            next_x_o = shifted + (W+2)'(1);
        end else begin
            lane_o   = W'(r);
            next_x_o = shifted;
        end
    end

endmodule

// File: rtl/signed_digit_decomposer.sv
// Serially splits a coefficient in [0, Q) into DIGITS balanced signed digits,
// one per cycle, and presents them mod Q as a packed lane bus.
module signed_digit_decomposer
    import signed_digit_decomposer_pkg::*;
#(
    parameter int Q      = 12289,
    parameter int LOG_B  = 7,
    parameter int DIGITS = NTT_NUMBER,
    parameter int W      = DATA_SIZE_ARB
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        value_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DIGITS*W-1:0] value_out,
    output logic                out_err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    sdd_state_e           state_q;
    logic signed [W+1:0]  x_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DIGITS*W-1:0]  lanes_q;
    logic                 inReady_q;
    logic                 outValid_q;
    logic                 outErr_q;

    logic signed [W+1:0]  centered_d;
    logic        [W-1:0]  stepLane;
    logic signed [W+1:0]  stepNextX;

    // Map the upper half of [0, Q) to negatives so digits stay balanced.
    always_comb begin
        if (value_in > W'((Q - 1) / 2)) begin
            centered_d = $signed({2'b00, value_in}) - (W+2)'(Q);
        end else begin
            centered_d = $signed({2'b00, value_in});
        end
    end

    sdd_digit_step #(
        .Q     (Q),
        .LOG_B (LOG_B),
        .W     (W)
    ) u_step (
        .x_i      (x_q),
        .lane_o   (stepLane),
        .next_x_o (stepNextX)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SDD_IDLE;
            x_q        <= '0;
            cnt_q      <= '0;
            lanes_q    <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            outErr_q   <= 1'b0;
        end else begin
            case (state_q)
                SDD_IDLE: begin
                    if (in_valid) begin
                        x_q       <= centered_d;
                        cnt_q     <= '0;
                        lanes_q   <= '0;
                        outErr_q  <= 1'b0;
                        inReady_q <= 1'b0;
                        state_q   <= SDD_RUN;
                    end
                end
                SDD_RUN: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            lanes_q[k*W +: W] <= stepLane;
                        end
                    end
                    x_q <= stepNextX;
                    // Whatever is left after the last digit is the residual.
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        outErr_q   <= (stepNextX != '0);
                        outValid_q <= 1'b1;
                        state_q    <= SDD_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SDD_DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= SDD_IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= SDD_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign value_out = lanes_q;
    assign out_err   = outErr_q;

endmodule
